// File: rtl/nametable_write_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nametable_write_scheduler_pkg
// Purpose  : Shared PPU definitions for the name-table write path: table
//            geometry, VGA position width, scheduler state encoding, the
//            buffered request record and the fill-word helper.
// Revision : 1.0 - initial release
// ============================================================================
package nametable_write_scheduler_pkg;

  // Name-table geometry: 30 tile rows of 8 words (4 tiles per word).
  localparam int NT_WORDS     = 240;
  localparam int NT_TILE_ROWS = 30;
  localparam int NT_IDX_W     = 8;

  // Width of the VGA line counter.
  localparam int VGA_POS_W    = 10;

  // Width of the buffer occupancy count (covers depths up to 16).
  localparam int FIFO_LVL_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } nt_state_e;

  // One buffered write request as it sits in the request FIFO.
  typedef struct packed {
    logic [NT_IDX_W-1:0] idx;
    logic [31:0]         data;
    logic [3:0]          be;
  } nt_req_t;

  // A fill word carries the same tile index in all four byte lanes.
  function automatic logic [31:0] fill_word(input logic [7:0] tile);
    return {4{tile}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/nametable_write_scheduler_fifo.sv
`default_nettype none
// ============================================================================
// Module   : nt_req_fifo
// Purpose  : Small synchronous FIFO holding name-table write requests until
//            the display leaves the game area.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            flush             - discard all entries (wins over push)
//            push, push_data   - enqueue one entry (ignored when full)
//            pop               - dequeue the head entry (ignored when empty)
//            head_data         - current head entry (valid when !empty)
//            level, full, empty- occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module nt_req_fifo
  import nametable_write_scheduler_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 44
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_data,
  output logic [FIFO_LVL_W-1:0] level,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [FIFO_LVL_W-1:0] DEPTH_LVL = FIFO_LVL_W'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [WIDTH-1:0]      mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [FIFO_LVL_W-1:0] level_q, level_d;
  logic                  do_push;
  logic                  do_pop;

  assign full      = (level_q == DEPTH_LVL);
  assign empty     = (level_q == '0);
  assign level     = level_q;
  assign head_data = mem_q[rd_ptr_q];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: entries are only read while counted in level.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/nametable_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : nametable_write_scheduler
// Purpose  : Defers name-table RAM writes to the lines outside the game area
//            so the renderer never sees a half-updated table, and performs a
//            full-table fill on request.
// Ports    : clk, rst                     - clock, synchronous active-high reset
//            vgaPosY                      - current VGA line
//            wr_valid/wr_ready            - write-request handshake
//            wr_index/wr_data/wr_be       - word index, 4 tile indices, byte enables
//            clr_req, clr_tile            - full-table fill request and tile
//            ram_we/addr/wdata/be         - name-table RAM write port
//            busy, fifo_level, drop_err   - status
// Revision : 1.0 - initial release
// ============================================================================
module nametable_write_scheduler
  import nametable_write_scheduler_pkg::*;
#(
  parameter int GAME_START_POSY = 120,
  parameter int GAME_HEIGHT     = 240,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VGA_POS_W-1:0]  vgaPosY,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [NT_IDX_W-1:0]   wr_index,
  input  logic [31:0]           wr_data,
  input  logic [3:0]            wr_be,
  input  logic                  clr_req,
  input  logic [7:0]            clr_tile,
  output logic                  ram_we,
  output logic [NT_IDX_W-1:0]   ram_addr,
  output logic [31:0]           ram_wdata,
  output logic [3:0]            ram_be,
  output logic                  busy,
  output logic [FIFO_LVL_W-1:0] fifo_level,
  output logic                  drop_err
);

  localparam logic [VGA_POS_W-1:0] WIN_LO    = VGA_POS_W'(GAME_START_POSY);
  localparam logic [VGA_POS_W-1:0] WIN_HI    = VGA_POS_W'(GAME_START_POSY + GAME_HEIGHT);
  localparam logic [NT_IDX_W-1:0]  LAST_WORD = NT_IDX_W'(NT_WORDS - 1);

  nt_state_e             state_q, state_d;
  logic [VGA_POS_W-1:0]  vga_pos_y_q, vga_pos_y_d;
  logic [NT_IDX_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [7:0]            clr_tile_q, clr_tile_d;
  logic                  drop_err_q, drop_err_d;

  logic                  window_open;
  logic                  accept;
  logic                  bad_index;
  logic                  enter_clear;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_flush;
  logic                  fifo_full;
  logic                  fifo_empty;
  nt_req_t               push_req;
  nt_req_t               fifo_head;

  // Writes are only allowed above or below the rendered game area.
  assign window_open = (vga_pos_y_q < WIN_LO) || (vga_pos_y_q >= WIN_HI);

  assign wr_ready  = !fifo_full && (state_q != ST_CLEAR);
  assign accept    = wr_valid && wr_ready;
  assign bad_index = (wr_index > LAST_WORD);
  assign fifo_push = accept && !bad_index;
  assign push_req  = '{idx: wr_index, data: wr_data, be: wr_be};

  assign busy     = (state_q != ST_IDLE) || (fifo_level != '0);
  assign drop_err = drop_err_q;

  assign vga_pos_y_d = vgaPosY;
  assign drop_err_d  = drop_err_q || (accept && bad_index);

  nt_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(nt_req_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (push_req),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    clr_tile_d  = clr_tile_q;
    enter_clear = 1'b0;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    ram_be      = '0;

    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          enter_clear = 1'b1;
        end else if (!fifo_empty && window_open) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (window_open && !fifo_empty) begin
          fifo_pop  = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = fifo_head.idx;
          ram_wdata = fifo_head.data;
          ram_be    = fifo_head.be;
        end
        // A fill request lets this cycle's pop complete, then takes over.
        if (clr_req) begin
          enter_clear = 1'b1;
        end else if (!window_open || fifo_empty) begin
          state_d = ST_IDLE;
        end
      end

      ST_CLEAR: begin
        if (window_open) begin
          ram_we    = 1'b1;
          ram_addr  = clr_cnt_q;
          ram_wdata = fill_word(clr_tile_q);
          ram_be    = 4'hF;
          if (clr_cnt_q == LAST_WORD) begin
            state_d   = ST_IDLE;
            clr_cnt_d = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
          end
        end
        // A new request restarts the fill from word 0 with the new tile.
        if (clr_req) begin
          enter_clear = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Entering a fill discards everything buffered, including a same-cycle push.
    if (enter_clear) begin
      state_d    = ST_CLEAR;
      clr_cnt_d  = '0;
      clr_tile_d = clr_tile;
      fifo_flush = 1'b1;
    end

    // Reset abandons any operation immediately: no write in the reset cycle.
    if (rst) begin
      fifo_pop  = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      ram_be    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      vga_pos_y_q <= '0;
      clr_cnt_q   <= '0;
      clr_tile_q  <= '0;
      drop_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      vga_pos_y_q <= vga_pos_y_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_tile_q  <= clr_tile_d;
      drop_err_q  <= drop_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nametable_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_nametable_write_scheduler
// Purpose  : Self-checking bench for nametable_write_scheduler: a queue-based
//            reference model checked every cycle, directed scenarios with
//            literal expectations, then a randomized run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nametable_write_scheduler;

  localparam int GSP   = 120;
  localparam int GH    = 240;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  vgaPosY = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [7:0]  wr_index = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        clr_req = 1'b0;
  logic [7:0]  clr_tile = '0;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_be;
  logic        busy;
  logic [4:0]  fifo_level;
  logic        drop_err;

  nametable_write_scheduler #(
    .GAME_START_POSY (GSP),
    .GAME_HEIGHT     (GH),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vgaPosY    (vgaPosY),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_index   (wr_index),
    .wr_data    (wr_data),
    .wr_be      (wr_be),
    .clr_req    (clr_req),
    .clr_tile   (clr_tile),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_be     (ram_be),
    .busy       (busy),
    .fifo_level (fifo_level),
    .drop_err   (drop_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit [7:0]  idx;
    bit [31:0] data;
    bit [3:0]  be;
  } req_t;

  typedef struct {
    int        addr;
    bit [31:0] data;
    bit [3:0]  be;
    int        cyc;
  } wlog_t;

  localparam int M_IDLE = 0, M_DRAIN = 1, M_CLEAR = 2;

  req_t  m_q[$];
  int    m_mode;
  int    m_line;
  int    m_cnt;
  bit [7:0] m_tile;
  bit    m_drop;
  bit    m_valid = 1'b0;
  wlog_t wlog[$];

  task automatic model_reset();
    m_q.delete();
    m_mode = M_IDLE;
    m_line = 0;
    m_cnt  = 0;
    m_tile = '0;
    m_drop = 1'b0;
  endtask

  // Compare at the falling edge, then advance the model to the state the
  // DUT will hold after the next rising edge.
  always @(negedge clk) begin
    bit        open, e_ready, e_busy, e_we, acc, bad, qne;
    bit [7:0]  e_addr;
    bit [31:0] e_data;
    bit [3:0]  e_be;
    req_t      r;
    cyc++;
    if (!m_valid) begin
      if (rst === 1'b1) begin
        model_reset();
        m_valid = 1'b1;
      end
    end else begin
      open    = (m_line < GSP) || (m_line >= GSP + GH);
      e_ready = (m_q.size() < DEPTH) && (m_mode != M_CLEAR);
      e_busy  = (m_mode != M_IDLE) || (m_q.size() != 0);
      e_we = 1'b0; e_addr = '0; e_data = '0; e_be = '0;
      if (!rst) begin
        if (m_mode == M_DRAIN && open && m_q.size() > 0) begin
          e_we = 1'b1; e_addr = m_q[0].idx; e_data = m_q[0].data; e_be = m_q[0].be;
        end else if (m_mode == M_CLEAR && open) begin
          e_we = 1'b1; e_addr = 8'(m_cnt); e_data = {4{m_tile}}; e_be = 4'hF;
        end
      end
      chk("ram_port", {ram_we, ram_addr, ram_wdata, ram_be}, {e_we, e_addr, e_data, e_be});
      chk("wr_ready", wr_ready, e_ready);
      chk("busy", busy, e_busy);
      chk("fifo_level", fifo_level, m_q.size());
      chk("drop_err", drop_err, m_drop);

      if (rst) begin
        model_reset();
      end else begin
        qne = (m_q.size() != 0);
        acc = wr_valid && e_ready;
        bad = (wr_index > 8'd239);
        if (acc && bad) m_drop = 1'b1;
        if (e_we && m_mode == M_DRAIN) void'(m_q.pop_front());
        if (acc && !bad) begin
          r.idx = wr_index; r.data = wr_data; r.be = wr_be;
          m_q.push_back(r);
        end
        if (clr_req) begin
          m_q.delete();
          m_mode = M_CLEAR;
          m_cnt  = 0;
          m_tile = clr_tile;
        end else if (m_mode == M_IDLE) begin
          if (qne && open) m_mode = M_DRAIN;
        end else if (m_mode == M_DRAIN) begin
          if (!open || !qne) m_mode = M_IDLE;
        end else if (open) begin
          if (m_cnt == 239) begin
            m_mode = M_IDLE;
            m_cnt  = 0;
          end else begin
            m_cnt++;
          end
        end
        m_line = int'(vgaPosY);
      end
    end
    if (ram_we === 1'b1) begin
      wlog.push_back('{addr: int'(ram_addr), data: ram_wdata, be: ram_be, cyc: cyc});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_valid = 1'b0; clr_req = 1'b0;
    cycles(2);
    rst = 1'b0;
    cycles(1);
  endtask

  task automatic push1(input int idx, input logic [31:0] d, input logic [3:0] be);
    wr_valid = 1'b1; wr_index = 8'(idx); wr_data = d; wr_be = be;
    cycles(1);
    wr_valid = 1'b0;
  endtask

  task automatic wait_log(input int k, input int bound, input string name);
    for (int i = 0; i < bound && wlog.size() < k; i++) cycles(1);
    chk(name, wlog.size() >= k, 1);
  endtask

  initial begin
    int n1, n2, nbad, line;

    // Reset state
    cycles(2);
    rst = 1'b0;
    cycles(1);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_drop_err", drop_err, 0);
    chk("rst_ram_we", ram_we, 0);

    // Single write in an open window drains on the following cycle.
    vgaPosY = 10'd400;
    cycles(2);
    wlog.delete();
    push1(5, 32'h01020304, 4'hF);
    wait_log(1, 10, "single_write_seen");
    if (wlog.size() >= 1) begin
      chk("single_addr", wlog[0].addr, 5);
      chk("single_data", wlog[0].data, 32'h01020304);
      chk("single_be", wlog[0].be, 4'hF);
    end

    // Closed window: buffer fills, nothing written, then drains in order.
    do_reset();
    vgaPosY = 10'd200;
    cycles(2);
    wlog.delete();
    for (int i = 0; i < 4; i++) push1(20 + i, 32'hA0000000 + 32'(i), 4'(i + 1));
    chk("closed_full_ready", wr_ready, 0);
    chk("closed_full_level", fifo_level, 4);
    cycles(10);
    chk("closed_no_write", wlog.size(), 0);
    vgaPosY = 10'd360;
    wait_log(4, 20, "closed_drain_seen");
    if (wlog.size() >= 4) begin
      nbad = 0;
      for (int i = 0; i < 4; i++) begin
        if (wlog[i].addr != 20 + i || wlog[i].data != 32'hA0000000 + 32'(i) ||
            wlog[i].cyc != wlog[0].cyc + i) nbad++;
      end
      chk("closed_drain_order", nbad, 0);
    end

    // Out-of-range index is dropped and flagged until reset.
    do_reset();
    vgaPosY = 10'd400;
    cycles(2);
    wlog.delete();
    push1(240, 32'hDEADBEEF, 4'hF);
    cycles(1);
    chk("drop_flag", drop_err, 1);
    chk("drop_level", fifo_level, 0);
    cycles(5);
    chk("drop_no_write", wlog.size(), 0);
    chk("drop_sticky", drop_err, 1);
    do_reset();
    chk("drop_cleared", drop_err, 0);

    // Full-table fill with a pause while the window is closed.
    vgaPosY = 10'd0;
    cycles(2);
    wlog.delete();
    clr_req = 1'b1; clr_tile = 8'h2A;
    cycles(1);
    clr_req = 1'b0; clr_tile = 8'h55;
    cycles(100);
    vgaPosY = 10'd200;
    cycles(2);
    n1 = wlog.size();
    cycles(18);
    n2 = wlog.size();
    chk("clear_paused", n2, n1);
    chk("clear_busy_paused", busy, 1);
    vgaPosY = 10'd400;
    wait_log(240, 300, "clear_done_seen");
    cycles(3);
    chk("clear_count", wlog.size(), 240);
    nbad = 0;
    for (int i = 0; i < wlog.size() && i < 240; i++) begin
      if (wlog[i].addr != i || wlog[i].data != 32'h2A2A2A2A || wlog[i].be != 4'hF) nbad++;
    end
    chk("clear_contents", nbad, 0);
    chk("clear_idle_busy", busy, 0);

    // Reset in the middle of a fill stops all writes.
    do_reset();
    vgaPosY = 10'd0;
    cycles(2);
    wlog.delete();
    clr_req = 1'b1; clr_tile = 8'h77;
    cycles(1);
    clr_req = 1'b0;
    wait_log(100, 300, "midclear_reached");
    rst = 1'b1;
    n1 = wlog.size();
    cycles(1);
    rst = 1'b0;
    cycles(50);
    chk("midclear_no_write", wlog.size(), n1);
    chk("midclear_busy", busy, 0);
    chk("midclear_level", fifo_level, 0);
    chk("midclear_ready", wr_ready, 1);

    // Simultaneous push and pop keeps the level constant and order intact.
    do_reset();
    vgaPosY = 10'd200;
    cycles(2);
    wlog.delete();
    for (int i = 0; i < 3; i++) push1(10 + i, 32'h100 + 32'(i), 4'hF);
    vgaPosY = 10'd400;
    wait_log(1, 10, "pp_first_pop");
    chk("pp_level_a", fifo_level, 2);
    push1(13, 32'h103, 4'hF);
    chk("pp_level_b", fifo_level, 2);
    push1(14, 32'h104, 4'hF);
    chk("pp_level_c", fifo_level, 2);
    wait_log(5, 20, "pp_all_seen");
    if (wlog.size() >= 5) begin
      nbad = 0;
      for (int i = 0; i < 5; i++) begin
        if (wlog[i].addr != 10 + i || wlog[i].data != 32'h100 + 32'(i)) nbad++;
      end
      chk("pp_order", nbad, 0);
    end

    // Randomized run against the model.
    do_reset();
    line = 0;
    for (int c = 0; c < 4000; c++) begin
      line = ($urandom_range(0, 99) < 2) ? int'($urandom_range(0, 524)) : (line + 1) % 525;
      vgaPosY  = 10'(line);
      wr_valid = ($urandom_range(0, 99) < 40);
      wr_index = ($urandom_range(0, 99) < 4) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 239));
      wr_data  = $urandom;
      wr_be    = 4'($urandom_range(0, 15));
      clr_req  = ($urandom_range(0, 399) == 0);
      clr_tile = 8'($urandom_range(0, 255));
      rst      = ($urandom_range(0, 1499) == 0);
      cycles(1);
    end
    rst = 1'b0; wr_valid = 1'b0; clr_req = 1'b0;
    cycles(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
